// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes,
// opcode values, alu_op codes and the alu_src_b / pc_src mux selects.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_MTYPE = 2'b00;
    localparam logic [1:0] ALU_BTYPE = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_JTYPE = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_opcode_decoder.sv
// mc_opcode_decoder: maps the IR opcode to the state that follows DECODE.
// Unsupported opcodes return FETCH with illegal set.
// MC_BNE_EN: when defined, bne (000101) is accepted and routed to BRANCH.
module mc_opcode_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] opcode_i,
    output state_e     next_state_o,
    output logic       illegal_o
);

    // Pure lookup; default is the illegal path back to FETCH.
    always_comb begin
        next_state_o = S_FETCH;
        illegal_o    = 1'b0;
        case (opcode_i)
            OP_RTYPE:      next_state_o = S_R_EXEC;
            OP_LW, OP_SW:  next_state_o = S_MEM_ADDR;
            OP_BEQ:        next_state_o = S_BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:        next_state_o = S_BRANCH;
`endif
            OP_J:          next_state_o = S_JUMP;
            OP_ADDI:       next_state_o = S_ADDI_EXEC;
            default:       illegal_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multi-cycle MIPS datapath.
// Level outputs are Moore outputs of the state register; ir_write/pc_write
// in FETCH are qualified by mem_ready. Counts retired instructions and keeps
// a sticky illegal-opcode flag.
// Handshake: a memory request (mem_read/mem_write) is a level held while in
// FETCH/MEM_READ/MEM_WRITE; the access completes in any cycle where mem_ready
// is 1, including the first cycle of the wait state.
// MC_BNE_EN: enables bne (000101) via BRANCH with branch_ne=1.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal_op,
    output logic [RET_W-1:0] retired,
    output logic [3:0]       dbg_state_o
);

    state_e           state_q, state_d;
    state_e           dec_next;
    logic             dec_illegal;
    logic             is_sw_q;
    logic             illegal_q;
    logic             retire;
    logic [RET_W-1:0] retired_q;

    mc_opcode_decoder u_dec (
        .opcode_i     (opcode),
        .next_state_o (dec_next),
        .illegal_o    (dec_illegal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Opcode is only looked at in DECODE: remember lw/sw choice and the
    // illegal flag (sticky until reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_sw_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state_q == S_DECODE) begin
            is_sw_q <= (opcode == OP_SW);
            if (dec_illegal) illegal_q <= 1'b1;
        end
    end

`ifdef MC_BNE_EN
    logic bne_q;
    // Remember whether the branch being decoded is bne.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    bne_q <= 1'b0;
        else if (state_q == S_DECODE)  bne_q <= (opcode == OP_BNE);
    end
`else
    logic bne_q;
    assign bne_q = 1'b0;
`endif

    // Retired-instruction counter, wraps naturally at 2^RET_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired_q <= '0;
        else if (retire) retired_q <= retired_q + 1'b1;
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_MTYPE;
        pc_src        = PC_SRC_ALU;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                state_d   = dec_next;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_BTYPE;
                pc_src        = PC_SRC_ALUOUT;
                pc_write_cond = 1'b1;
                branch_ne     = bne_q;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign illegal_op  = illegal_q;
    assign retired     = retired_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller (RET_W=4 so the counter wrap is reached).
// Each instruction is expanded into an expected per-cycle trace of
// (state, mem_ready drive, opcode drive) from the instruction-level timing
// rules; outputs are predicted per state from the control table.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam int RET_W = 4;
    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101;
    localparam logic [5:0] T_J = 6'b000010, T_ADDI = 6'b001000, T_BAD = 6'b111111;

    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = '0;
    logic mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
    logic reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [RET_W-1:0] retired;
    logic [3:0] dbg_state_o;

    multicycle_controller #(.RET_W(RET_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op),
        .retired(retired), .dbg_state_o(dbg_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ret  = 0;
    logic exp_ill = 1'b0;

    typedef struct {
        state_e     st;
        logic       rdy;
        logic [5:0] op;
        logic       bne;
    } step_t;
    step_t trace[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Control table: {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
    //  branch_ne, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}
    function automatic logic [16:0] exp_outs(input state_e st, input logic rdy, input logic bne);
        logic mr, mw, iod, irw, pcw, pcc, bn, rw, rd, m2r, sa;
        logic [1:0] sb, ao, ps;
        {mr, mw, iod, irw, pcw, pcc, bn, rw, rd, m2r, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            S_FETCH:     begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:    sb = 2'b11;
            S_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
            S_MEM_READ:  begin mr = 1; iod = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 1; end
            S_MEM_WRITE: begin mw = 1; iod = 1; end
            S_R_EXEC:    begin sa = 1; ao = 2'b10; end
            S_R_WB:      begin rw = 1; rd = 1; end
            S_BRANCH:    begin sa = 1; ao = 2'b01; ps = 2'b01; pcc = 1; bn = bne; end
            S_JUMP:      begin ps = 2'b10; pcw = 1; end
            S_ADDI_EXEC: begin sa = 1; sb = 2'b10; end
            S_ADDI_WB:   rw = 1;
            default:     ;
        endcase
        return {mr, mw, iod, irw, pcw, pcc, bn, rw, rd, m2r, sa, sb, ao, ps};
    endfunction

    function automatic logic [16:0] dut_outs();
        return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};
    endfunction

    // Opcode and mem_ready are junk in cycles where the controller must ignore them.
    task automatic push(input state_e st, input logic rdy, input logic bne);
        step_t s;
        s.st = st; s.rdy = rdy; s.op = 6'($urandom); s.bne = bne;
        trace.push_back(s);
    endtask

    task automatic push_wait(input state_e st, input int waits);
        for (int i = 0; i < waits; i++) push(st, 1'b0, 1'b0);
        push(st, 1'b1, 1'b0);
    endtask

    // Expand one instruction into its cycle-by-cycle trace.
    task automatic build(input logic [5:0] op, input int fw, input int mw, output logic legal);
        step_t s;
        legal = 1'b1;
        trace.delete();
        push_wait(S_FETCH, fw);
        s.st = S_DECODE; s.rdy = 1'($urandom); s.op = op; s.bne = 1'b0;
        trace.push_back(s);
        case (op)
            T_R:    begin push(S_R_EXEC, 1'($urandom), 0); push(S_R_WB, 1'($urandom), 0); end
            T_LW:   begin push(S_MEM_ADDR, 1'($urandom), 0); push_wait(S_MEM_READ, mw);
                          push(S_MEM_WB, 1'($urandom), 0); end
            T_SW:   begin push(S_MEM_ADDR, 1'($urandom), 0); push_wait(S_MEM_WRITE, mw); end
            T_BEQ:  push(S_BRANCH, 1'($urandom), 0);
            T_J:    push(S_JUMP, 1'($urandom), 0);
            T_ADDI: begin push(S_ADDI_EXEC, 1'($urandom), 0); push(S_ADDI_WB, 1'($urandom), 0); end
`ifdef MC_BNE_EN
            T_BNE:  push(S_BRANCH, 1'($urandom), 1);
`endif
            default: legal = 1'b0;
        endcase
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_state"}, 32'(dbg_state_o), 32'(S_IDLE));
        check_eq({tag, "_outs"}, 32'(dut_outs()), 32'd0);
        check_eq({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check_eq({tag, "_retired"}, 32'(retired), 32'd0);
        check_eq({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    endtask

    // Release reset just after a rising edge; the following cycle shows IDLE.
    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("post_rst");
    endtask

    // Play the current trace; abort_at >= 0 pulls rst_n low inside that cycle.
    task automatic run(input logic legal, input int abort_at);
        foreach (trace[i]) begin
            @(posedge clk); #1;
            opcode = trace[i].op;
            mem_ready = trace[i].rdy;
            @(negedge clk);
            check_eq($sformatf("state@%s", trace[i].st.name()), 32'(dbg_state_o), 32'(trace[i].st));
            check_eq($sformatf("outs@%s", trace[i].st.name()), 32'(dut_outs()),
                     32'(exp_outs(trace[i].st, trace[i].rdy, trace[i].bne)));
            check_eq("retired", 32'(retired), 32'(exp_ret));
            check_eq("illegal_op", 32'(illegal_op), 32'(exp_ill));
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_state("mid_rst");
                exp_ret = 0;
                exp_ill = 1'b0;
                release_reset();
                return;
            end
        end
        if (legal) exp_ret = (exp_ret + 1) % (1 << RET_W);
        else       exp_ill = 1'b1;
    endtask

    task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
        logic legal;
        build(op, fw, mw, legal);
        run(legal, -1);
    endtask

    initial begin
        logic legal;
        logic [5:0] ops[8];
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI, T_BNE, T_BAD};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("in_rst");
        release_reset();

        // Directed: each instruction class, then stalls and illegal opcodes.
        do_instr(T_R, 0, 0);
        check_eq("r_len", 32'(trace.size()), 32'd4);
        do_instr(T_LW, 0, 3);
        check_eq("lw_stall_len", 32'(trace.size()), 32'd8);
        do_instr(T_ADDI, 2, 0);
        do_instr(T_SW, 0, 0);
        do_instr(T_BEQ, 0, 0);
        do_instr(T_J, 1, 0);
        do_instr(T_BAD, 0, 0);
        do_instr(T_BNE, 0, 0);
        do_instr(T_R, 0, 0);

        // Enough jumps to wrap the 4-bit counter.
        for (int k = 0; k < 17; k++) do_instr(T_J, $urandom_range(1, 0), 0);

        // Random instruction mix with random stalls.
        for (int k = 0; k < 60; k++) begin
            logic [5:0] op;
            op = ($urandom_range(9, 0) == 0) ? 6'($urandom) : ops[$urandom_range(7, 0)];
            do_instr(op, $urandom_range(3, 0), $urandom_range(3, 0));
        end

        // Reset in the middle of a stalled store.
        exp_ill = exp_ill;
        build(T_SW, 0, 4, legal);
        run(legal, 4);
        do_instr(T_R, 0, 0);
        do_instr(T_LW, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
